// File: rtl/bus_pair_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pair_receiver_if
//  Purpose  : Handshake and payload bundle for the two-bus pair link.
//             i0 is declared [HI:LO] and i1 is declared [LO:HI] on the way in.
//             On the way out the declared ranges are reversed: o0 is [LO:HI]
//             and o1 is [HI:LO]. Indices are preserved across the crossing.
//  Ports    : in_valid/in_ready/i0/i1  producer side
//             out_valid/out_ready/o0/o1 consumer side
//             count                     occupancy, 0..DEPTH
//             in_par/out_par_err/par_err_sticky
//                                       present only with BUS_PAIR_RX_PARITY_EN
//  Modports : master = environment (producer + consumer), slave = receiver
//  Config   : BUS_PAIR_RX_PARITY_EN adds the parity signals
//  Revision : 1.0  initial release
// ============================================================================
interface bus_pair_receiver_if #(
    parameter int HI = 2,
    parameter int LO = -2,
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [HI:LO]  i0;
    logic [LO:HI]  i1;
    logic          out_valid;
    logic          out_ready;
    logic [LO:HI]  o0;
    logic [HI:LO]  o1;
    logic [AW:0]   count;
`ifdef BUS_PAIR_RX_PARITY_EN
    logic          in_par;
    logic          out_par_err;
    logic          par_err_sticky;

    modport master (
        output in_valid, i0, i1, in_par, out_ready,
        input  in_ready, out_valid, o0, o1, count, out_par_err, par_err_sticky
    );
    modport slave (
        input  in_valid, i0, i1, in_par, out_ready,
        output in_ready, out_valid, o0, o1, count, out_par_err, par_err_sticky
    );
`else
    modport master (
        output in_valid, i0, i1, out_ready,
        input  in_ready, out_valid, o0, o1, count
    );
    modport slave (
        input  in_valid, i0, i1, out_ready,
        output in_ready, out_valid, o0, o1, count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bus_pair_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pair_receiver
//  Purpose  : Receiving end of the two-bus link. Each accepted {i0,i1} pair is
//             buffered in a DEPTH-entry FIFO and re-emitted with each bus's
//             declared range reversed, preserving index k on both buses.
//  Ports    : clk   - single clock, rising edge
//             rst   - asynchronous active-high reset (synchronous release
//                     expected from the reset source)
//             bus   - bus_pair_receiver_if.slave (handshakes, payloads, count,
//                     optional parity signals)
//  Params   : HI, LO (bus index bounds, LO may be negative), DEPTH (power of
//             two, >=2), AW = log2(DEPTH)
//  Config   : `define BUS_PAIR_RX_PARITY_EN to store a parity bit per pair
//             and report out_par_err / par_err_sticky
//  Revision : 1.0  initial release
// ============================================================================
module bus_pair_receiver #(
    parameter int HI    = 2,
    parameter int LO    = -2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_pair_receiver_if.slave    bus
);

    localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    // Storage keeps each bus in its input declaration order; the range
    // reversal happens only on the read side, bit by bit.
    logic [HI:LO]  mem_i0_q [DEPTH];
    logic [LO:HI]  mem_i1_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;

`ifdef BUS_PAIR_RX_PARITY_EN
    logic          mem_par_q [DEPTH];
    logic          par_err_sticky_q, par_err_sticky_d;
    logic          w_head_par_err;
`endif

    // ------------------------------------------------------------------
    // Handshake and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // in_ready ignores out_ready, so a full FIFO never passes data
        // through on a same-cycle pop.
        w_in_ready  = !rst && (count_q != c_full);
        w_out_valid = (count_q != '0);
        w_push      = bus.in_valid && w_in_ready;
        w_pop       = w_out_valid && bus.out_ready;

        wr_ptr_d = w_push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;

        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // State registers. Storage is cleared on reset so that the head output
    // reads zero and stale pairs can never resurface afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_i0_q[e] <= '0;
                mem_i1_q[e] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push) begin
                mem_i0_q[wr_ptr_q] <= bus.i0;
                mem_i1_q[wr_ptr_q] <= bus.i1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head read: index-preserving crossing into the reversed ranges.
    // Whole-vector assignment here would mirror the bits, so map each k.
    // ------------------------------------------------------------------
    always_comb begin
        bus.o0 = '0;
        bus.o1 = '0;
        for (int k = LO; k <= HI; k++) begin
            bus.o0[k] = mem_i0_q[rd_ptr_q][k];
            bus.o1[k] = mem_i1_q[rd_ptr_q][k];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.count     = count_q;

`ifdef BUS_PAIR_RX_PARITY_EN
    // ------------------------------------------------------------------
    // Parity: stored bit plus both payloads must XOR to zero (even parity
    // over 2W+1 bits). The sticky flag records any errored pair consumed.
    // ------------------------------------------------------------------
    always_comb begin
        w_head_par_err   = w_out_valid &&
                           ((^bus.o0) ^ (^bus.o1) ^ mem_par_q[rd_ptr_q]);
        par_err_sticky_d = par_err_sticky_q || (w_pop && w_head_par_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_sticky_q <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_par_q[e] <= 1'b0;
            end
        end else begin
            par_err_sticky_q <= par_err_sticky_d;
            if (w_push) begin
                mem_par_q[wr_ptr_q] <= bus.in_par;
            end
        end
    end

    assign bus.out_par_err    = w_head_par_err;
    assign bus.par_err_sticky = par_err_sticky_q;
`endif

endmodule
`default_nettype wire
